// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: shared FSM state type and default parameters for the chess clock
package chess_clock_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, TIMEOUT} clk_state_t;
    localparam int DEF_CLK_DIV  = 50_000_000;
    localparam int DEF_INIT_SEC = 180;
    localparam int DEF_INC_SEC  = 0;
    localparam int DEF_TIME_W   = 10;
endpackage

// File: rtl/chess_clock_tick_gen.sv
// tick_gen: one-second prescaler, emits a one-cycle tick on each wrap
// Ports: clk, reset (sync, active-high), clr (force count to 0), en (count), tick (wrap pulse)
module tick_gen
    import chess_clock_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(CLK_DIV - 1);
    // With en low the count is held, so a pause resumes mid-second
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/chess_clock.sv
// chess_clock: two-player countdown clock with Fischer increment and timeout detection
// Ports: clk, reset (sync, active-high), start, pause, move_done (inputs);
//        side (0 white / 1 black), w_min/w_sec, b_min/b_sec (remaining time),
//        w_to/b_to (time expired), running (high in RUN)
module chess_clock
    import chess_clock_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int INIT_SEC = DEF_INIT_SEC,
    parameter int INC_SEC  = DEF_INC_SEC,
    parameter int TIME_W   = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              move_done,
    output logic              side,
    output logic [TIME_W-6:0] w_min,
    output logic [5:0]        w_sec,
    output logic [TIME_W-6:0] b_min,
    output logic [5:0]        b_sec,
    output logic              w_to,
    output logic              b_to,
    output logic              running
);
    localparam int MAX = 2 ** TIME_W - 1;

    if (INIT_SEC > MAX) begin : g_bad_init
        $error("INIT_SEC does not fit in TIME_W bits");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end

    clk_state_t        state;
    logic [TIME_W-1:0] w_cnt, b_cnt, cur, dec, inc, nxt;
    logic [31:0]       sum;
    logic              tick, expire, toggle;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (state == IDLE),
        .en   (state == RUN),
        .tick (tick)
    );

    // tick only fires in RUN, so these values are consumed only there.
    // Order: decrement, then increment, then toggle; reaching zero suppresses the rest.
    always_comb begin
        cur    = side ? b_cnt : w_cnt;
        dec    = (tick && cur != '0) ? cur - TIME_W'(1) : cur;
        sum    = 32'(dec) + 32'(INC_SEC);
        inc    = sum > 32'(MAX) ? TIME_W'(MAX) : sum[TIME_W-1:0];
        expire = tick && cur == TIME_W'(1);
        nxt    = expire ? '0 : move_done ? inc : dec;
        toggle = move_done && !expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            w_cnt   <= TIME_W'(INIT_SEC);
            b_cnt   <= TIME_W'(INIT_SEC);
            side    <= 1'b0;
            running <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    side    <= 1'b0;
                    running <= 1'b1;
                end
                RUN: begin
                    if (side) b_cnt <= nxt;
                    else w_cnt <= nxt;
                    if (toggle) side <= ~side;
                    if (expire || w_to || b_to) begin
                        state   <= TIMEOUT;
                        running <= 1'b0;
                    end else if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                PAUSED: if (!pause) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
                TIMEOUT: ;
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign w_to  = w_cnt == '0;
    assign b_to  = b_cnt == '0;
    assign w_min = (TIME_W-5)'(32'(w_cnt) / 32'd60);
    assign w_sec = 6'(32'(w_cnt) % 32'd60);
    assign b_min = (TIME_W-5)'(32'(b_cnt) / 32'd60);
    assign b_sec = 6'(32'(b_cnt) % 32'd60);
endmodule

// File: tb/tb_chess_clock.sv
// tb_chess_clock: scenario bench for chess_clock with CLK_DIV=4, INIT_SEC=5, INC_SEC=2
module tb_chess_clock;
    import chess_clock_pkg::*;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, pause = 1'b0, move_done = 1'b0;
    logic       side, w_to, b_to, running;
    logic [4:0] w_min, b_min;
    logic [5:0] w_sec, b_sec;
    logic [27:0] obs, e;
    string       n;
    int          vectors = 0, miscompares = 0;
    string       name_q[$];
    logic [27:0] exp_q[$];

    chess_clock #(.CLK_DIV(4), .INIT_SEC(5), .INC_SEC(2), .TIME_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .move_done(move_done),
        .side(side), .w_min(w_min), .w_sec(w_sec), .b_min(b_min), .b_sec(b_sec),
        .w_to(w_to), .b_to(b_to), .running(running)
    );

    always #5 clk = ~clk;

    assign obs = {dut.state, side, running, w_to, b_to, w_min, w_sec, b_min, b_sec};

    function automatic logic [27:0] snap(input int w, input int b, input int s, input int r, input clk_state_t st);
        return {st, 1'(s), 1'(r), w == 0, b == 0, 5'(w / 60), 6'(w % 60), 5'(b / 60), 6'(b % 60)};
    endfunction

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic want(input string nm, input logic [27:0] v);
        name_q.push_back(nm);
        exp_q.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic start_play();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_move();
        move_done = 1'b1;
        step(1);
        move_done = 1'b0;
    endtask

    task automatic test_reset();
        want("reset_state", snap(5, 5, 0, 0, IDLE));
        do_reset();
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("idle_hold", snap(5, 5, 0, 0, IDLE));
        step(6);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_countdown();
        do_reset();
        start_play();
        want("cd_before_tick", snap(5, 5, 0, 1, RUN));
        step(3);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("cd_first_tick", snap(4, 5, 0, 1, RUN));
        step(1);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("cd_one_left", snap(1, 5, 0, 1, RUN));
        step(12);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("cd_timeout", snap(0, 5, 0, 0, TIMEOUT));
        step(4);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("cd_timeout_terminal", snap(0, 5, 0, 0, TIMEOUT));
        start = 1'b1;
        pulse_move();
        step(8);
        start = 1'b0;
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("reset_from_timeout", snap(5, 5, 0, 0, IDLE));
        do_reset();
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_move_inc();
        do_reset();
        start_play();
        step(4);
        want("mv_increment", snap(6, 5, 1, 1, RUN));
        pulse_move();
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("mv_no_clear", snap(6, 5, 1, 1, RUN));
        step(2);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("mv_black_tick", snap(6, 4, 1, 1, RUN));
        step(1);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_pause();
        do_reset();
        start_play();
        step(2);
        pause = 1'b1;
        want("pause_enter", snap(5, 5, 0, 0, PAUSED));
        step(1);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("pause_frozen", snap(5, 5, 0, 0, PAUSED));
        step(4);
        pulse_move();
        step(4);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        pause = 1'b0;
        want("pause_resume", snap(5, 5, 0, 1, RUN));
        step(1);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("pause_partial_tick", snap(4, 5, 0, 1, RUN));
        step(1);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_simul_timeout();
        do_reset();
        start_play();
        want("st_w_one", snap(1, 5, 0, 1, RUN));
        step(19);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("st_timeout_wins", snap(0, 5, 0, 0, TIMEOUT));
        pulse_move();
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_simul_normal();
        do_reset();
        start_play();
        step(11);
        want("sn_dec_then_inc", snap(4, 5, 1, 1, RUN));
        pulse_move();
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("sn_black_runs", snap(4, 4, 1, 1, RUN));
        step(4);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_play();
        want("bb_three_moves", snap(9, 7, 1, 1, RUN));
        pulse_move();
        pulse_move();
        pulse_move();
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("bb_tick_on_black", snap(9, 6, 1, 1, RUN));
        step(1);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_play();
        pulse_move();
        want("rm_b_two", snap(7, 2, 1, 1, RUN));
        step(11);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("rm_restored", snap(5, 5, 0, 0, IDLE));
        move_done = 1'b1;
        do_reset();
        move_done = 1'b0;
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
        want("rm_idle_move_ignored", snap(5, 5, 0, 0, IDLE));
        pulse_move();
        step(8);
        vectors++; e = exp_q.pop_front(); n = name_q.pop_front();
        if (obs !== e) begin miscompares++; $display("FAIL %s: got %h expected %h", n, obs, e); end
    endtask

    initial begin
        step(1);
        test_reset();
        test_countdown();
        test_move_inc();
        test_pause();
        test_simul_timeout();
        test_simul_normal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
